// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for the multiplexed 7-segment scan bus: debounces each slot,
// decodes segments back to BCD and reports complete frames. Optional macro: SEG_SCAN_SYNC_EN.
module seg_scan_decoder #(
  parameter int NUM_DIG    = 6,
  parameter int STABLE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_DIG-1:0]     sel,
  input  logic [7:0]             dig,
  output logic [4*NUM_DIG-1:0]   digits,
  output logic [NUM_DIG-1:0]     dp,
  output logic                   frame_valid,
  output logic                   err_pattern,
  output logic                   err_sel
);

  localparam int SW = NUM_DIG + 8;
  localparam logic [7:0] STABLE_N = 8'(STABLE_CYC);

  logic [SW-1:0] in_w;

`ifdef SEG_SCAN_SYNC_EN
  logic [SW-1:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {sel, dig};
      sync2 <= sync1;
    end
  end
  assign in_w = sync2;
`else
  assign in_w = {sel, dig};
`endif

  logic [SW-1:0]        s;
  logic [7:0]           cnt;
  logic                 captured;
  logic [NUM_DIG-1:0]   mask;
  logic [4*NUM_DIG-1:0] shadow;
  logic [NUM_DIG-1:0]   shadow_dp;

  logic                 same;
  logic [7:0]           cnt_next;
  logic                 cap_keep;
  logic                 slot_evt;
  logic [NUM_DIG-1:0]   sel_low;
  logic                 onehot;
  logic                 multi;
  logic [3:0]           code;
  logic                 code_ok;
  logic                 cap_en;
  logic                 mask_full;
  logic [NUM_DIG-1:0]   mask_next;

  // The slot is classified from the value being registered this edge, so a
  // STABLE_CYC of 1 captures on the very edge the new sample arrives.
  always_comb begin
    same      = (in_w == s);
    cnt_next  = !same ? 8'd1 : ((cnt < STABLE_N) ? cnt + 8'd1 : cnt);
    cap_keep  = same & captured;
    slot_evt  = (cnt_next == STABLE_N) && !cap_keep;
    sel_low   = ~in_w[SW-1:8];
    onehot    = (sel_low != '0) &&
                ((sel_low & (sel_low - {{(NUM_DIG-1){1'b0}}, 1'b1})) == '0);
    multi     = (sel_low != '0) && !onehot;
    code      = 4'h0;
    code_ok   = 1'b1;
    case (in_w[6:0])
      7'h40: code = 4'h0;
      7'h79: code = 4'h1;
      7'h24: code = 4'h2;
      7'h30: code = 4'h3;
      7'h19: code = 4'h4;
      7'h12: code = 4'h5;
      7'h02: code = 4'h6;
      7'h78: code = 4'h7;
      7'h00: code = 4'h8;
      7'h10: code = 4'h9;
      7'h7F: code = 4'hF;
      default: code_ok = 1'b0;
    endcase
    cap_en    = slot_evt && onehot && code_ok;
    mask_full = &mask;
    mask_next = (mask_full ? '0 : mask) | (cap_en ? sel_low : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s           <= '1;
      cnt         <= 8'd0;
      captured    <= 1'b0;
      mask        <= '0;
      digits      <= '0;
      dp          <= '0;
      frame_valid <= 1'b0;
      err_pattern <= 1'b0;
      err_sel     <= 1'b0;
    end else begin
      s           <= in_w;
      cnt         <= cnt_next;
      captured    <= cap_keep | slot_evt;
      mask        <= mask_next;
      frame_valid <= mask_full;
      err_pattern <= slot_evt && onehot && !code_ok;
      err_sel     <= slot_evt && multi;
      if (mask_full) begin
        digits <= shadow;
        dp     <= shadow_dp;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIG; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          shadow[4*gi +: 4] <= 4'h0;
          shadow_dp[gi]     <= 1'b0;
        end else if (cap_en && sel_low[gi]) begin
          shadow[4*gi +: 4] <= code;
          shadow_dp[gi]     <= ~in_w[7];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of scan slots plus glitch and reset sequences.
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [5:0]  sel;
  logic [7:0]  dig;
  logic [23:0] digits;
  logic [5:0]  dp;
  logic        frame_valid;
  logic        err_pattern;
  logic        err_sel;

  int cmp;
  int mism;
  int fv_cnt;
  int ep_cnt;
  int es_cnt;

  seg_scan_decoder #(.NUM_DIG(6), .STABLE_CYC(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (sel),
    .dig         (dig),
    .digits      (digits),
    .dp          (dp),
    .frame_valid (frame_valid),
    .err_pattern (err_pattern),
    .err_sel     (err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled just after each active edge.
  always begin
    @(posedge clk);
    #1;
    if (frame_valid) fv_cnt = fv_cnt + 1;
    if (err_pattern) ep_cnt = ep_cnt + 1;
    if (err_sel)     es_cnt = es_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp = cmp + 1;
    if (act !== exp) begin
      mism = mism + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // Entered and left at a negedge; holds the slot for 'hold' active edges.
  task automatic run_slot(input logic [5:0] s_i, input logic [7:0] d_i, input int hold,
                          input int efv, input int eep, input int ees, input string nm);
    int f0, e0, x0;
    f0 = fv_cnt; e0 = ep_cnt; x0 = es_cnt;
    sel = s_i;
    dig = d_i;
    repeat (hold) @(negedge clk);
    chk({nm, "_fv"}, 32'(fv_cnt - f0), 32'(efv));
    chk({nm, "_ep"}, 32'(ep_cnt - e0), 32'(eep));
    chk({nm, "_es"}, 32'(es_cnt - x0), 32'(ees));
  endtask

  typedef struct {
    logic [5:0]  s;
    logic [7:0]  d;
    int          fv;
    int          ep;
    int          es;
    bit          chk_frame;
    logic [23:0] exp_digits;
    logic [5:0]  exp_dp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    cmp = 0; mism = 0; fv_cnt = 0; ep_cnt = 0; es_cnt = 0;
    rst_n = 1'b0;
    sel   = 6'h3F;
    dig   = 8'hFF;

    // "12:34:56", then error slots, then a frame skipping and later filling position 1.
    tbl[0]  = '{6'b111111, 8'hFF, 0, 0, 0, 0, 24'h0,      6'h00};
    tbl[1]  = '{6'b011111, 8'hF9, 0, 0, 0, 0, 24'h0,      6'h00};
    tbl[2]  = '{6'b101111, 8'hA4, 0, 0, 0, 0, 24'h0,      6'h00};
    tbl[3]  = '{6'b110111, 8'hB0, 0, 0, 0, 0, 24'h0,      6'h00};
    tbl[4]  = '{6'b111011, 8'h99, 0, 0, 0, 0, 24'h0,      6'h00};
    tbl[5]  = '{6'b111101, 8'h92, 0, 0, 0, 0, 24'h0,      6'h00};
    tbl[6]  = '{6'b111110, 8'h82, 1, 0, 0, 1, 24'h123456, 6'h00};
    tbl[7]  = '{6'b111101, 8'hFE, 0, 1, 0, 0, 24'h0,      6'h00};
    tbl[8]  = '{6'b111100, 8'hC0, 0, 0, 1, 0, 24'h0,      6'h00};
    tbl[9]  = '{6'b111111, 8'hFF, 0, 0, 0, 0, 24'h0,      6'h00};
    tbl[10] = '{6'b011111, 8'hFF, 0, 0, 0, 0, 24'h0,      6'h00};
    tbl[11] = '{6'b101111, 8'hC0, 0, 0, 0, 0, 24'h0,      6'h00};
    tbl[12] = '{6'b110111, 8'h40, 0, 0, 0, 0, 24'h0,      6'h00};
    tbl[13] = '{6'b111011, 8'hC0, 0, 0, 0, 0, 24'h0,      6'h00};
    tbl[14] = '{6'b111110, 8'hC0, 0, 0, 0, 0, 24'h0,      6'h00};
    tbl[15] = '{6'b111101, 8'hC0, 1, 0, 0, 1, 24'hF00000, 6'b001000};
    tbl[16] = '{6'b111111, 8'hFF, 0, 0, 0, 0, 24'h0,      6'h00};

    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_pulses", {29'd0, frame_valid, err_pattern, err_sel}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_slot(tbl[i].s, tbl[i].d, 10, tbl[i].fv, tbl[i].ep, tbl[i].es, $sformatf("tbl%0d", i));
      if (tbl[i].chk_frame) begin
        chk($sformatf("tbl%0d_digits", i), 32'(digits), 32'(tbl[i].exp_digits));
        chk($sformatf("tbl%0d_dp", i), 32'(dp), 32'(tbl[i].exp_dp));
      end
    end

    // Glitch rejection: a 3-sample slot is ignored, a 4-sample slot captures.
    run_slot(6'b011111, 8'hF9, 10, 0, 0, 0, "gl_p5");
    run_slot(6'b101111, 8'hA4, 10, 0, 0, 0, "gl_p4");
    run_slot(6'b110111, 8'hB0, 10, 0, 0, 0, "gl_p3");
    run_slot(6'b111011, 8'h99, 10, 0, 0, 0, "gl_p2");
    run_slot(6'b111101, 8'h92, 10, 0, 0, 0, "gl_p1");
    run_slot(6'b111110, 8'h80,  3, 0, 0, 0, "gl_short");
    run_slot(6'b111111, 8'hFF, 10, 0, 0, 0, "gl_blank");
    run_slot(6'b111110, 8'h80,  4, 0, 0, 0, "gl_exact");
    run_slot(6'b111111, 8'hFF,  6, 1, 0, 0, "gl_done");
    chk("gl_digits", 32'(digits), 32'h123458);

    // Reset mid-frame: partial captures and outputs are discarded.
    run_slot(6'b011111, 8'hF9, 10, 0, 0, 0, "rm_p5");
    run_slot(6'b101111, 8'hA4, 10, 0, 0, 0, "rm_p4");
    run_slot(6'b110111, 8'hB0, 10, 0, 0, 0, "rm_p3");
    sel = 6'h3F;
    dig = 8'hFF;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_rst_digits", 32'(digits), 32'h0);
    chk("rm_rst_dp", 32'(dp), 32'h0);
    chk("rm_rst_fv", {31'd0, frame_valid}, 32'h0);
    rst_n = 1'b1;
    run_slot(6'b111110, 8'hC0, 10, 0, 0, 0, "rm_q0");
    run_slot(6'b111101, 8'hC0, 10, 0, 0, 0, "rm_q1");
    run_slot(6'b111011, 8'hC0, 10, 0, 0, 0, "rm_q2");
    run_slot(6'b110111, 8'hC0, 10, 0, 0, 0, "rm_q3");
    run_slot(6'b101111, 8'hC0, 10, 0, 0, 0, "rm_q4");
    run_slot(6'b011111, 8'hC0, 10, 1, 0, 0, "rm_q5");
    chk("rm_digits", 32'(digits), 32'h0);
    chk("rm_dp", 32'(dp), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
